flappy_game_ctrl: RTL



---
 rtl/flappy_pkg.sv | 19 +
 rtl/flappy_game_ctrl_edge_sync.sv | 29 ++
 rtl/flappy_game_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// Shared state encoding and default game constants for the flappy controller.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DEAD = 2'b10
  } game_state_e;

  localparam int GRAVITY_DEF      = 1;
  localparam int FLAP_VEL_DEF     = -6;
  localparam int MAX_FALL_DEF     = 8;
  localparam int BIRD_Y_INIT_DEF  = 200;
  localparam int FLOOR_Y_DEF      = 450;
  localparam int COLUMN_PITCH_DEF = 160;
  localparam int SCROLL_WRAP_DEF  = 640;
  localparam int DEAD_HOLD_DEF    = 30;

endpackage

// File: rtl/flappy_game_ctrl_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge detector producing a one-cycle pulse.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic [2:0] sync_q;
  logic [1:0] valid_q;
  logic       armed_q;

  // A level already high when reset releases must not count as an edge:
  // edges are only accepted after a genuine low has come through the synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      valid_q <= '0;
      armed_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], din};
      valid_q <= {valid_q[0], 1'b1};
      if (valid_q[1] && !sync_q[1]) armed_q <= 1'b1;
      pulse   <= armed_q && sync_q[1] && !sync_q[2];
    end
  end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy-bird game controller: frame-stepped bird physics, scrolling, scoring and game FSM.
// state | meaning
// IDLE  | bird parked at start height, waiting for a flap
// PLAY  | physics, scroll and score advance every frame
// DEAD  | outputs frozen, counting frames before a restart flap is accepted
module flappy_game_ctrl
  import flappy_pkg::*;
#(
  parameter int GRAVITY      = GRAVITY_DEF,
  parameter int FLAP_VEL     = FLAP_VEL_DEF,
  parameter int MAX_FALL     = MAX_FALL_DEF,
  parameter int BIRD_Y_INIT  = BIRD_Y_INIT_DEF,
  parameter int FLOOR_Y      = FLOOR_Y_DEF,
  parameter int COLUMN_PITCH = COLUMN_PITCH_DEF,
  parameter int SCROLL_WRAP  = SCROLL_WRAP_DEF,
  parameter int DEAD_HOLD    = DEAD_HOLD_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       screenEnd,
  input  logic       flap,
  input  logic       hit,
  output logic [8:0] bird_y,
  output logic [9:0] scroll_x,
  output logic [7:0] score,
  output logic [1:0] state
);

  localparam logic signed [7:0]  GRAV_V      = 8'(GRAVITY);
  localparam logic signed [7:0]  MAX_FALL_V  = 8'(MAX_FALL);
  localparam logic signed [7:0]  FLAP_V      = 8'(FLAP_VEL);
  localparam logic signed [11:0] FLOOR_V     = 12'(FLOOR_Y);
  localparam logic [8:0]         FLOOR_Y9    = 9'(FLOOR_Y);
  localparam logic [8:0]         INIT_Y9     = 9'(BIRD_Y_INIT);
  localparam logic [9:0]         SCROLL_LAST = 10'(SCROLL_WRAP - 1);
  localparam logic [7:0]         PITCH_LAST  = 8'(COLUMN_PITCH - 1);
  localparam logic [7:0]         HOLD_V      = 8'(DEAD_HOLD);

  game_state_e       state_q, state_d;
  logic [8:0]        bird_y_q, bird_y_d;
  logic signed [5:0] vel_q, vel_d;
  logic [9:0]        scroll_q, scroll_d;
  logic [7:0]        pitch_q, pitch_d;
  logic [7:0]        score_q, score_d;
  logic [7:0]        dead_cnt_q, dead_cnt_d;
  logic              flap_pend_q, flap_pend_d;
  logic              hit_pend_q, hit_pend_d;
  logic              frame_tick, flap_evt;

  edge_sync u_frame_sync (.clk(clk), .reset(reset), .din(screenEnd), .pulse(frame_tick));
  edge_sync u_flap_sync  (.clk(clk), .reset(reset), .din(flap),      .pulse(flap_evt));

  logic signed [7:0]  vel_ext, vel_grav, vel_sel;
  logic signed [11:0] y_sum;
  logic               y_lo, y_hi, crash, pitch_wrap;
  logic [8:0]         y_next;
  logic signed [5:0]  vel_next;
  logic [9:0]         scroll_inc;
  logic [7:0]         pitch_inc, dead_inc;

  // Velocity and position worked in widened signed arithmetic, then clamped to the screen.
  assign vel_ext    = {{2{vel_q[5]}}, vel_q};
  assign vel_grav   = vel_ext + GRAV_V;
  assign vel_sel    = flap_pend_q ? FLAP_V : ((vel_grav > MAX_FALL_V) ? MAX_FALL_V : vel_grav);
  assign y_sum      = $signed({3'b000, bird_y_q}) + $signed({{4{vel_sel[7]}}, vel_sel});
  assign y_lo       = y_sum < 12'sd0;
  assign y_hi       = y_sum >= FLOOR_V;
  assign y_next     = y_lo ? 9'd0 : (y_hi ? FLOOR_Y9 : y_sum[8:0]);
  assign vel_next   = y_lo ? 6'sd0 : vel_sel[5:0];
  assign crash      = hit_pend_q || (y_next == FLOOR_Y9);
  assign scroll_inc = (scroll_q == SCROLL_LAST) ? 10'd0 : scroll_q + 10'd1;
  assign pitch_wrap = pitch_q == PITCH_LAST;
  assign pitch_inc  = pitch_wrap ? 8'd0 : pitch_q + 8'd1;
  assign dead_inc   = (dead_cnt_q == 8'hFF) ? 8'hFF : dead_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    bird_y_d    = bird_y_q;
    vel_d       = vel_q;
    scroll_d    = scroll_q;
    pitch_d     = pitch_q;
    score_d     = score_q;
    dead_cnt_d  = dead_cnt_q;
    flap_pend_d = frame_tick ? flap_evt : (flap_pend_q | flap_evt);
    hit_pend_d  = frame_tick ? hit : (hit_pend_q | hit);
    case (state_q)
      ST_IDLE: begin
        if (frame_tick && flap_pend_q) begin
          state_d  = ST_PLAY;
          bird_y_d = y_next;
          vel_d    = vel_next;
          scroll_d = '0;
          pitch_d  = '0;
          score_d  = '0;
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          bird_y_d = y_next;
          vel_d    = vel_next;
          scroll_d = scroll_inc;
          pitch_d  = pitch_inc;
          if (crash) begin
            state_d    = ST_DEAD;
            dead_cnt_d = '0;
          end else if (pitch_wrap && score_q != 8'hFF) begin
            score_d = score_q + 8'd1;
          end
        end
      end
      ST_DEAD: begin
        if (frame_tick) begin
          if (flap_pend_q && dead_inc >= HOLD_V) begin
            state_d  = ST_IDLE;
            bird_y_d = INIT_Y9;
            vel_d    = '0;
          end else begin
            dead_cnt_d = dead_inc;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        bird_y_d = INIT_Y9;
        vel_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bird_y_q    <= INIT_Y9;
      vel_q       <= '0;
      scroll_q    <= '0;
      pitch_q     <= '0;
      score_q     <= '0;
      dead_cnt_q  <= '0;
      flap_pend_q <= 1'b0;
      hit_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bird_y_q    <= bird_y_d;
      vel_q       <= vel_d;
      scroll_q    <= scroll_d;
      pitch_q     <= pitch_d;
      score_q     <= score_d;
      dead_cnt_q  <= dead_cnt_d;
      flap_pend_q <= flap_pend_d;
      hit_pend_q  <= hit_pend_d;
    end
  end

  assign bird_y   = bird_y_q;
  assign scroll_x = scroll_q;
  assign score    = score_q;
  assign state    = state_q;

endmodule
